// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame length, transmitter state encoding and parity helper.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_HIGH = 2'd1,
    BIT_LOW  = 2'd2,
    GAP      = 2'd3
  } ps2_state_e;

  // Parity bit that makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous byte FIFO; pointers wrap modulo DEPTH (power of two).
module ps2_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               pop_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: pops queued bytes and drives 11-bit frames on ps2_clk/ps2_data.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_HALVES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int HPW = $clog2(HALF_PERIOD);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [HPW-1:0] HP_LAST  = HPW'(HALF_PERIOD - 1);
  localparam logic [HPW-1:0] HP_PRE   = HPW'(HALF_PERIOD - 2);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_HALVES - 1);

  ps2_state_e            state_q, state_d;
  logic [HPW-1:0]        hp_cnt_q, hp_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  ps2_clk_q, ps2_clk_d;
  logic                  ps2_data_q, ps2_data_d;
  logic                  frame_done_q, frame_done_d;

  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [7:0]            fifo_data;
  logic [CW-1:0]         fifo_count;
  logic                  phase_end;

  ps2_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign phase_end = (hp_cnt_q == HP_LAST);

  always_comb begin
    state_d      = state_q;
    hp_cnt_d     = hp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ps2_clk_d    = ps2_clk_q;
    ps2_data_d   = ps2_data_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        hp_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = {1'b1, odd_parity(fifo_data), fifo_data, 1'b0};
          bit_cnt_d  = '0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
          state_d    = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        hp_cnt_d = hp_cnt_q + HPW'(1);
        if (phase_end) begin
          hp_cnt_d  = '0;
          ps2_clk_d = 1'b0;
          state_d   = BIT_LOW;
        end
      end
      BIT_LOW: begin
        hp_cnt_d = hp_cnt_q + HPW'(1);
        // Registered pulse must land on the final cycle of the stop bit's low phase.
        frame_done_d = (bit_cnt_q == LAST_BIT) && (hp_cnt_q == HP_PRE);
        if (phase_end) begin
          hp_cnt_d  = '0;
          ps2_clk_d = 1'b1;
          if (bit_cnt_q != LAST_BIT) begin
            shift_d    = {1'b0, shift_q[FRAME_BITS-1:1]};
            ps2_data_d = shift_q[1];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            state_d    = BIT_HIGH;
          end else begin
            ps2_data_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        hp_cnt_d = hp_cnt_q + HPW'(1);
        if (phase_end) begin
          hp_cnt_d = '0;
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hp_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign frame_done = frame_done_q;
  assign tx_ready   = !fifo_full;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a PS/2 host model decodes the line.
module tb_ps2_device_tx;

  localparam int HP    = 50;
  localparam int GAP_H = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, ps2_clk, ps2_data, busy, frame_done;

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_HALVES(GAP_H), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] exp_q[$];
  logic       par_log[$];

  // Host-side receiver model: samples data on ps2_clk falling edges.
  int          nbits = 0, frames = 0, fd_count = 0, edges = 0;
  int          last_fall = 0, stop_fall = 0, idle_run = 0, last_start_cyc = -1;
  bit          fd_pending = 0, had_frame = 0;
  logic [10:0] fbits, last_fbits;
  logic        prev_clk = 1'b1, prev_data = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; fd_pending = 0; had_frame = 0; idle_run = 0;
      prev_clk = 1'b1; prev_data = 1'b1;
    end else begin
      if (ps2_clk != prev_clk) edges++;
      if (ps2_clk && prev_clk && prev_data && !ps2_data && nbits == 0) begin
        last_start_cyc = cyc;
        if (had_frame) chk("inter_frame_gap_ge_min", longint'(idle_run >= GAP_H*HP), 1);
        if (fd_pending) begin
          chk("frame_done_missing", 0, 1);
          fd_pending = 0;
        end
      end
      if (!ps2_clk && !prev_clk) chk("data_stable_while_clk_low", ps2_data, prev_data);
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0) chk("bit_period", cyc - last_fall, 2*HP);
        last_fall    = cyc;
        fbits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          logic [7:0] eb;
          frames++;
          par_log.push_back(fbits[9]);
          last_fbits = fbits;
          nbits      = 0;
          fd_pending = 1;
          had_frame  = 1;
          stop_fall  = cyc;
          chk("start_bit", fbits[0], 0);
          chk("stop_bit", fbits[10], 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 0, 1);
          end else begin
            eb = exp_q.pop_front();
            chk("byte", fbits[8:1], eb);
            chk("parity", fbits[9], longint'($countones(eb) % 2 == 0));
          end
        end
      end
      if (!prev_clk && ps2_clk) chk("clk_low_width", cyc - last_fall, HP);
      if (frame_done) begin
        fd_count++;
        chk("frame_done_expected", fd_pending, 1);
        chk("frame_done_cycle", cyc, stop_fall + HP - 1);
        fd_pending = 0;
      end
      if (ps2_clk && ps2_data) idle_run++; else idle_run = 0;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, output int acc);
    int n = 0;
    while (!tx_ready && n < 5000) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    acc = cyc;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy || fd_pending) && n < 20000) begin
      tick();
      n++;
    end
    chk("drain_timeout", longint'(n < 20000), 1);
  endtask

  initial begin
    int acc, n, idx, acc_before, fd_base, edge_base;
    bit seen_stall, stalled;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 1: single byte, latency and exact bit pattern
    push(8'h1C, acc);
    chk("t1_line_idle_n1", ps2_data, 1);
    tick();
    chk("t1_start_cycle", cyc, acc + 2);
    chk("t1_start_data", ps2_data, 0);
    chk("t1_busy", busy, 1);
    n = 0;
    while (!frame_done && n < 3000) begin tick(); n++; end
    chk("t1_frame_done_cycle", cyc, acc + 1 + 22*HP);
    drain();
    chk("t1_bits", last_fbits, 11'h438);

    // 2: make/break sequence back-to-back
    for (int i = 0; i < 3; i++) begin
      logic [7:0] seq_b;
      seq_b = (i == 1) ? 8'hF0 : 8'h1C;
      chk("t2_ready_high", tx_ready, 1);
      push(seq_b, acc);
    end
    drain();

    // 3: hold tx_valid with 0x00..0x09
    tx_valid = 1'b1; tx_data = 8'h00; idx = 0; n = 0;
    acc_before = 0; seen_stall = 0; stalled = 0;
    while (idx < 10 && n < 30000) begin
      if (tx_ready) begin
        if (stalled) begin
          chk("t3_ready_rerise_at_pop", cyc, last_start_cyc);
          stalled = 0;
        end
        exp_q.push_back(tx_data);
        idx++;
        if (!seen_stall) acc_before++;
      end else begin
        if (!seen_stall) chk("t3_accepted_before_full", acc_before, 5);
        seen_stall = 1;
        stalled    = 1;
      end
      tick();
      n++;
      tx_data = idx[7:0];
    end
    tx_valid = 1'b0;
    chk("t3_all_accepted", idx, 10);
    drain();

    // 4: parity corner bytes
    par_log.delete();
    push(8'h00, acc); push(8'hFF, acc); push(8'h01, acc); push(8'h80, acc);
    drain();
    chk("t4_par_count", par_log.size(), 4);
    if (par_log.size() == 4) begin
      chk("t4_par_00", par_log[0], 1);
      chk("t4_par_ff", par_log[1], 1);
      chk("t4_par_01", par_log[2], 0);
      chk("t4_par_80", par_log[3], 0);
    end

    // random bursts of scan codes with random idle spacing
    for (int k = 0; k < 6; k++) begin
      int burst;
      burst = $urandom_range(1, 3);
      for (int j = 0; j < burst; j++) push(8'($urandom_range(0, 255)), acc);
      for (int g = $urandom_range(0, 1500); g > 0; g--) tick();
    end
    drain();

    // 5: reset during d3 low phase with two bytes still queued
    push(8'hA5, acc); push(8'h3C, acc); push(8'h7E, acc);
    n = 0;
    while (nbits != 5 && n < 3000) begin tick(); n++; end
    chk("t5_reach_d3", nbits, 5);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_clk_low_before_reset", ps2_clk, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_ps2_clk", ps2_clk, 1);
    chk("t5_reset_ps2_data", ps2_data, 1);
    chk("t5_reset_frame_done", frame_done, 0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    fd_base = fd_count; edge_base = edges;
    tick();
    chk("t5_busy_after", busy, 0);
    chk("t5_ready_after", tx_ready, 1);
    for (int i = 0; i < 3000; i++) tick();
    chk("t5_no_edges", edges - edge_base, 0);
    chk("t5_no_frame_done", fd_count - fd_base, 0);
    chk("t5_busy_idle", busy, 0);

    chk("frame_done_per_frame", fd_count, frames);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
